// File: rtl/decoder_3_8.sv
// decoder_3_8: 3-to-8 one-hot select decoder with optional output register and polarity control
module decoder_3_8 #(
    parameter bit REG_OUT       = 1'b0,
    parameter bit ACTIVE_LOW    = 1'b0,
    parameter bit EN_DEFAULT_ON = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] in,
    input  logic       en,
    output logic [7:0] y,
    output logic       valid
);
    logic [7:0] hot;
    logic [7:0] hot_sel;
    logic       valid_sel;
    logic       unused_ok;

    // one-hot decode; an unknown en or in falls through to the all-clear default
    always_comb begin
        hot = 8'h00;
        if (en) begin
            case (in)
                3'd0:    hot = 8'h01;
                3'd1:    hot = 8'h02;
                3'd2:    hot = 8'h04;
                3'd3:    hot = 8'h08;
                3'd4:    hot = 8'h10;
                3'd5:    hot = 8'h20;
                3'd6:    hot = 8'h40;
                3'd7:    hot = 8'h80;
                default: hot = 8'h00;
            endcase
        end
    end

    generate
        if (REG_OUT) begin : g_reg
            // output register; reset clears any in-flight select immediately
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    hot_sel   <= 8'h00;
                    valid_sel <= 1'b0;
                end else begin
                    hot_sel   <= hot;
                    valid_sel <= |hot;
                end
            end
        end else begin : g_comb
            assign hot_sel   = hot;
            assign valid_sel = |hot;
        end
    endgenerate

    // polarity applied last so the reset value also honours ACTIVE_LOW
    assign y         = ACTIVE_LOW ? ~hot_sel : hot_sel;
    assign valid     = valid_sel;
    assign unused_ok = ^{clk, rst, EN_DEFAULT_ON};
endmodule

// File: tb/tb_decoder_3_8.sv
// tb_decoder_3_8: checks all four REG_OUT/ACTIVE_LOW variants against a behavioural model
module tb_decoder_3_8;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] in  = 3'd0;
    logic       en  = 1'b0;
    logic [7:0] y_c, y_l, y_r, y_rl;
    logic       v_c, v_l, v_r, v_rl;
    logic [7:0] exp_q = 8'h00;
    int         errors = 0;
    int         checks = 0;

    typedef struct {
        logic [2:0] in;
        logic       en;
        logic [7:0] y;
    } vec_t;

    decoder_3_8 #(.REG_OUT(1'b0), .ACTIVE_LOW(1'b0)) dut_c  (.clk(clk), .rst(rst), .in(in), .en(en), .y(y_c),  .valid(v_c));
    decoder_3_8 #(.REG_OUT(1'b0), .ACTIVE_LOW(1'b1)) dut_l  (.clk(clk), .rst(rst), .in(in), .en(en), .y(y_l),  .valid(v_l));
    decoder_3_8 #(.REG_OUT(1'b1), .ACTIVE_LOW(1'b0)) dut_r  (.clk(clk), .rst(rst), .in(in), .en(en), .y(y_r),  .valid(v_r));
    decoder_3_8 #(.REG_OUT(1'b1), .ACTIVE_LOW(1'b1)) dut_rl (.clk(clk), .rst(rst), .in(in), .en(en), .y(y_rl), .valid(v_rl));

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_hot(logic [2:0] i, logic e);
        return (e === 1'b1 && !$isunknown(i)) ? (8'd1 << i) : 8'd0;
    endfunction

    // reference for the registered variants: last sampled decode, cleared by reset
    always @(posedge clk or posedge rst) begin
        if (rst) exp_q <= 8'h00;
        else     exp_q <= ref_hot(in, en);
    end

    task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t in=%b en=%b)", nm, act, exp, $time, in, en);
        end
    endtask

    task automatic check_all(string tag);
        logic [7:0] e;
        e = ref_hot(in, en);
        chk({tag, " y_comb"},     y_c,  e);
        chk({tag, " v_comb"},     {7'd0, v_c},  {7'd0, e != 8'h00});
        chk({tag, " y_comb_al"},  y_l,  ~e);
        chk({tag, " v_comb_al"},  {7'd0, v_l},  {7'd0, e != 8'h00});
        chk({tag, " y_reg"},      y_r,  exp_q);
        chk({tag, " v_reg"},      {7'd0, v_r},  {7'd0, exp_q != 8'h00});
        chk({tag, " y_reg_al"},   y_rl, ~exp_q);
        chk({tag, " v_reg_al"},   {7'd0, v_rl}, {7'd0, exp_q != 8'h00});
        chk({tag, " onehot"}, {7'd0, $countones(y_c) <= 1 && $countones(~y_l) <= 1 &&
                                     $countones(y_r) <= 1 && $countones(~y_rl) <= 1}, 8'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[10];
        tbl[0] = '{3'd0, 1'b1, 8'h01};
        tbl[1] = '{3'd1, 1'b1, 8'h02};
        tbl[2] = '{3'd2, 1'b1, 8'h04};
        tbl[3] = '{3'd3, 1'b1, 8'h08};
        tbl[4] = '{3'd4, 1'b1, 8'h10};
        tbl[5] = '{3'd5, 1'b1, 8'h20};
        tbl[6] = '{3'd6, 1'b1, 8'h40};
        tbl[7] = '{3'd7, 1'b1, 8'h80};
        tbl[8] = '{3'd5, 1'b0, 8'h00};
        tbl[9] = '{3'd5, 1'b1, 8'h20};

        #1;
        chk("reset y_reg", y_r, 8'h00);
        chk("reset v_reg", {7'd0, v_r}, 8'd0);
        chk("reset y_reg_al", y_rl, 8'hFF);
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in = tbl[i].in;
            en = tbl[i].en;
            #1;
            chk($sformatf("table%0d y", i), y_c, tbl[i].y);
            chk($sformatf("table%0d y_al", i), y_l, ~tbl[i].y);
            chk($sformatf("table%0d valid", i), {7'd0, v_c}, {7'd0, tbl[i].en});
            check_all($sformatf("table%0d", i));
        end

        @(negedge clk);
        in = 3'd3; en = 1'b1; #1;
        chk("al in3", y_l, 8'hF7);
        in = 3'd0; #1;
        chk("al in0", y_l, 8'hFE);
        en = 1'b0; #1;
        chk("al en0", y_l, 8'hFF);

        en = 1'b1; in = 3'd7;
        @(posedge clk); #1;
        chk("reg prev 80", y_r, 8'h80);
        @(negedge clk);
        in = 3'd6; #1;
        chk("reg not before edge", y_r, 8'h80);
        @(posedge clk); #1;
        chk("reg in6 after edge", y_r, 8'h40);
        @(negedge clk);
        in = 3'd1;
        @(posedge clk); #1;
        chk("reg in1", y_r, 8'h02);
        check_all("reg seq");

        @(negedge clk);
        in = 3'd7;
        @(posedge clk); #2;
        chk("pre-rst y", y_r, 8'h80);
        rst = 1'b1; #1;
        chk("async rst y", y_r, 8'h00);
        chk("async rst v", {7'd0, v_r}, 8'd0);
        chk("async rst y_al", y_rl, 8'hFF);
        chk("comb ignores rst", y_c, 8'h80);
        @(posedge clk); #1;
        chk("rst held y", y_r, 8'h00);
        @(negedge clk);
        in = 3'd2; rst = 1'b0; #1;
        chk("rst released no edge", y_r, 8'h00);
        @(posedge clk); #1;
        chk("first decode after rst", y_r, 8'h04);
        check_all("rst seq");

        @(negedge clk);
        in = 3'bx1x; en = 1'b1; #1;
        check_all("x comb");
        @(posedge clk); #1;
        check_all("x reg");

        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            in = 3'($urandom_range(0, 7));
            en = ($urandom_range(0, 3) != 0);
            #1;
            check_all("rand");
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1; #1;
                check_all("rand rst");
                rst = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
